// File: rtl/rtc_edit_ctrl.sv
// rtc_edit_ctrl: front-panel edit controller for the RTC counter bank.
// Turns debounced button levels into a field select code and single-cycle up/down
// strobes (with auto-repeat), then runs a write-request handshake on exit.
module rtc_edit_ctrl #(
    parameter int NUM_FIELDS    = 9,
    parameter int HOLD_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD = 12_500_000,
    parameter int WR_TIMEOUT    = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_prog,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       wr_ack,
    output logic [3:0] en_count,
    output logic       en_up,
    output logic       en_down,
    output logic       edit_active,
    output logic       wr_req,
    output logic       wr_err
);

    localparam int RPT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int WT_W    = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

    localparam logic [3:0]       LAST_FIELD = 4'(NUM_FIELDS);
    localparam logic [RPT_W-1:0] HOLD_LAST  = RPT_W'(HOLD_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [WT_W-1:0]  WT_LAST    = WT_W'(WR_TIMEOUT - 1);

    // Bit positions inside the button vectors.
    localparam int B_PROG  = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_UP    = 3;
    localparam int B_DOWN  = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [4:0]       btn_s_q,    btn_s_d;     // registered button levels
    logic [4:0]       btn_p_q,    btn_p_d;     // previous registered levels, for edge detect
    logic [3:0]       en_count_q, en_count_d;
    logic             en_up_q,    en_up_d;
    logic             en_down_q,  en_down_d;
    logic             wr_err_q,   wr_err_d;
    logic             armed_q,    armed_d;     // a strobe was issued and the button is still held
    logic             rpt_dir_q,  rpt_dir_d;   // 0: repeating up, 1: repeating down
    logic             rpt_mode_q, rpt_mode_d;  // 0: waiting hold delay, 1: periodic repeat
    logic [RPT_W-1:0] rpt_cnt_q,  rpt_cnt_d;
    logic [WT_W-1:0]  wt_cnt_q,   wt_cnt_d;

    logic [4:0] rise;
    logic       hold_up;
    logic       hold_dn;
    logic       field_chg;

    assign rise      = btn_s_q & ~btn_p_q;
    assign hold_up   = btn_s_q[B_UP] & ~btn_s_q[B_DOWN];
    assign hold_dn   = btn_s_q[B_DOWN] & ~btn_s_q[B_UP];
    // Left and right rising together cancel each other.
    assign field_chg = rise[B_RIGHT] ^ rise[B_LEFT];

    // Next-state, field select, strobe and repeat/timeout counter logic.
    always_comb begin
        state_d    = state_q;
        btn_s_d    = {btn_down, btn_up, btn_right, btn_left, btn_prog};
        btn_p_d    = btn_s_q;
        en_count_d = en_count_q;
        en_up_d    = 1'b0;
        en_down_d  = 1'b0;
        wr_err_d   = wr_err_q;
        armed_d    = armed_q;
        rpt_dir_d  = rpt_dir_q;
        rpt_mode_d = rpt_mode_q;
        rpt_cnt_d  = rpt_cnt_q;
        wt_cnt_d   = wt_cnt_q;

        case (state_q)
            S_IDLE: begin
                armed_d   = 1'b0;
                rpt_cnt_d = '0;
                wt_cnt_d  = '0;
                if (rise[B_PROG]) begin
                    state_d    = S_EDIT;
                    en_count_d = 4'd1;
                    wr_err_d   = 1'b0;
                end
            end

            S_EDIT: begin
                if (rise[B_PROG]) begin
                    state_d    = S_COMMIT;
                    en_count_d = 4'd0;
                    wt_cnt_d   = '0;
                    armed_d    = 1'b0;
                    rpt_cnt_d  = '0;
                end else if (field_chg) begin
                    if (rise[B_RIGHT]) begin
                        en_count_d = (en_count_q >= LAST_FIELD) ? 4'd1 : en_count_q + 4'd1;
                    end else begin
                        en_count_d = (en_count_q <= 4'd1) ? LAST_FIELD : en_count_q - 4'd1;
                    end
                    armed_d   = 1'b0;
                    rpt_cnt_d = '0;
                end else if (rise[B_UP] && hold_up) begin
                    en_up_d    = 1'b1;
                    armed_d    = 1'b1;
                    rpt_dir_d  = 1'b0;
                    rpt_mode_d = 1'b0;
                    rpt_cnt_d  = '0;
                end else if (rise[B_DOWN] && hold_dn) begin
                    en_down_d  = 1'b1;
                    armed_d    = 1'b1;
                    rpt_dir_d  = 1'b1;
                    rpt_mode_d = 1'b0;
                    rpt_cnt_d  = '0;
                end else if (armed_q && (rpt_dir_q ? hold_dn : hold_up)) begin
                    // rpt_cnt_q counts cycles since the last strobe, minus one.
                    if (rpt_cnt_q == (rpt_mode_q ? PER_LAST : HOLD_LAST)) begin
                        en_up_d    = ~rpt_dir_q;
                        en_down_d  = rpt_dir_q;
                        rpt_mode_d = 1'b1;
                        rpt_cnt_d  = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end else begin
                    // Released, both held, or never armed: repeat needs a fresh press.
                    armed_d   = 1'b0;
                    rpt_cnt_d = '0;
                end
            end

            S_COMMIT: begin
                if (wr_ack) begin
                    state_d = S_IDLE;
                end else if (wt_cnt_q == WT_LAST) begin
                    state_d  = S_IDLE;
                    wr_err_d = 1'b1;
                end else begin
                    wt_cnt_d = wt_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                en_count_d = 4'd0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            btn_s_q    <= '0;
            btn_p_q    <= '0;
            en_count_q <= '0;
            en_up_q    <= 1'b0;
            en_down_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            armed_q    <= 1'b0;
            rpt_dir_q  <= 1'b0;
            rpt_mode_q <= 1'b0;
            rpt_cnt_q  <= '0;
            wt_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            btn_s_q    <= btn_s_d;
            btn_p_q    <= btn_p_d;
            en_count_q <= en_count_d;
            en_up_q    <= en_up_d;
            en_down_q  <= en_down_d;
            wr_err_q   <= wr_err_d;
            armed_q    <= armed_d;
            rpt_dir_q  <= rpt_dir_d;
            rpt_mode_q <= rpt_mode_d;
            rpt_cnt_q  <= rpt_cnt_d;
            wt_cnt_q   <= wt_cnt_d;
        end
    end

    assign en_count    = en_count_q;
    assign en_up       = en_up_q;
    assign en_down     = en_down_q;
    assign edit_active = (state_q == S_EDIT);
    assign wr_req      = (state_q == S_COMMIT);
    assign wr_err      = wr_err_q;

endmodule

// File: doc/rtc_edit_ctrl.md
# rtc_edit_ctrl

Edit-mode controller for the RTC date/time counter bank. It turns debounced front-panel buttons into a field select code (`en_count`) and single-cycle up/down strobes, with auto-repeat while a button is held. Each field counter, such as the 2-digit day-of-month counter on code 6, acts on a strobe only when its code is selected. When the user leaves edit mode, the block runs a write-request handshake to the RTC bus interface so the edited values get committed.

## Interface
Parameters:
- `NUM_FIELDS`, 9: number of editable fields. Codes run 1..`NUM_FIELDS`; code 6 is day-of-month; code 0 means no field selected.
- `HOLD_DELAY`, 25_000_000: cycles from the first strobe to the first auto-repeat strobe.
- `REPEAT_PERIOD`, 12_500_000: cycles between auto-repeat strobes.
- `WR_TIMEOUT`, 1_000_000: maximum cycles to wait for `wr_ack`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `btn_prog`  in  1  program/exit button, synchronised and debounced level.
- `btn_left`  in  1  previous field, level.
- `btn_right`  in  1  next field, level.
- `btn_up`  in  1  increment, level.
- `btn_down`  in  1  decrement, level.
- `wr_ack`  in  1  commit accepted by the RTC bus interface.
- `en_count`  out  4  selected field code; 0 outside edit mode.
- `en_up`  out  1  one-cycle increment strobe.
- `en_down`  out  1  one-cycle decrement strobe.
- `edit_active`  out  1  high in the EDIT state.
- `wr_req`  out  1  commit request, held until acknowledged or timed out.
- `wr_err`  out  1  sticky commit-timeout flag.

## Operation
- All button inputs are registered once. A press is a rising edge, detected against that registered copy.
- State machine:
  - IDLE: `btn_prog` rise -> EDIT, with `en_count` set to 1 and `wr_err` cleared.
  - EDIT:
    - `btn_right` rise: `en_count` +1, wrapping `NUM_FIELDS` -> 1.
    - `btn_left` rise: `en_count` -1, wrapping 1 -> `NUM_FIELDS`.
    - `btn_prog` rise -> COMMIT.
  - COMMIT: `wr_req` is 1 and `en_count` is 0.
    - `wr_ack` high -> IDLE.
    - Wait counter reaching `WR_TIMEOUT` -> IDLE with `wr_err` set to 1.
- Up/down strobes are issued only in EDIT:
  - `btn_up` rise gives one `en_up` pulse; `btn_down` rise gives one `en_down` pulse.
  - While the same button stays high and the other stays low, the first repeat comes `HOLD_DELAY` cycles after the initial strobe, then one every `REPEAT_PERIOD` cycles.
  - Releasing the button resets the repeat counter.
- Priority within a cycle in EDIT: `btn_prog` > left/right > up/down.
  - A prog rise suppresses any field change or strobe in that cycle.
  - A field change in a cycle suppresses the strobe in that cycle and cancels any repeat in progress. A new rising edge is needed to restart repeat.
- Simultaneous events:
  - `btn_up` and `btn_down` both high: no strobe, and the repeat counter is cleared.
  - `btn_left` and `btn_right` rising in the same cycle: no field change.
- `en_up` and `en_down` are never high in the same cycle. Both are 0 whenever the state is not EDIT.
- A `wr_ack` arriving in IDLE or EDIT is ignored.
- `wr_err` stays set until the next entry into EDIT. A reset also clears it.

## Timing
- Reset values: state IDLE; `en_count`=0, `en_up`=0, `en_down`=0, `edit_active`=0, `wr_req`=0, `wr_err`=0; all counters 0.
- Press latency: when a button is first sampled high at edge N, its effect is visible after edge N+1. This covers the strobe, the field change and the state change.
- Strobe width: exactly 1 cycle.
- `edit_active` and `en_count` update in the same cycle as the state change.
- Commit handshake:
  - `wr_req` rises on the cycle COMMIT is entered.
  - With `wr_ack` sampled high at edge M, `wr_req` is 0 and the state is IDLE after edge M.
- Timeout: with no ack, IDLE and `wr_err`=1 take effect `WR_TIMEOUT` cycles after COMMIT entry.
- Reset mid-operation (e.g. during COMMIT or during auto-repeat) returns to the reset values immediately, asynchronously. No strobe or `wr_req` is produced afterwards until a fresh rising edge arrives.
- Counter widths are sized by `$clog2` of the respective parameter.

## Test plan
Directed scenarios use `HOLD_DELAY`=8, `REPEAT_PERIOD`=4, `WR_TIMEOUT`=16, `NUM_FIELDS`=9.

1. Entry and field navigation: reset, then pulse prog -> `edit_active`=1, `en_count`=1. Then right ×5 -> 6; left ×6 -> 9, confirming the wrap; right -> 1.
2. Single strobe and auto-repeat: hold up for 20 cycles in EDIT -> `en_up` pulses at relative cycles 1, 9, 13 and 17 (each 1 cycle wide), and never any `en_down`. Release, then press down once -> exactly one `en_down`.
3. Conflicting inputs:
   - Up and down held together -> no strobes.
   - Right and up rising in the same cycle -> `en_count` increments with no `en_up` that cycle.
   - Left and right rising together -> no change.
4. Commit with ack: prog in EDIT -> `wr_req`=1 and `en_count`=0. Assert `wr_ack` 3 cycles later -> `wr_req`=0, IDLE, `wr_err`=0.
5. Commit timeout: prog in EDIT, never assert `wr_ack` -> after 16 cycles `wr_req`=0 and `wr_err`=1. Re-entering EDIT clears `wr_err`.
6. Reset mid-repeat and mid-commit: assert reset asynchronously while up is held, and again while `wr_req`=1 -> all outputs 0 at once. Holding up after reset is released produces no strobe.
